// File: rtl/fifo_rd_stream.sv
// Drains a show-ahead async FIFO read port into a valid/ready stream through a
// two-entry skid buffer. It also generates m_last per packet and keeps a saturating pop count.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_inc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL2 = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] head, tail;
  logic [BW-1:0]         beat;
  logic                  pop, deq;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (pop) state_nxt = ONE;
      ONE:     if (pop && !deq) state_nxt = FULL2;
               else if (!pop && deq) state_nxt = EMPTY;
      FULL2:   if (deq) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Reset gates the pop so no word is consumed before the first edge out of reset.
  always_comb begin
    pop     = r_rst_n & ~r_empty & (state != FULL2);
    m_valid = (state != EMPTY);
  end

  assign r_inc  = pop;
  assign deq    = m_valid & m_ready;
  assign m_data = head;
  assign m_last = m_valid & (beat == LAST_BEAT);

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        EMPTY: if (pop) head <= r_data;
        ONE: begin
          if (pop && deq) head <= r_data;
          else if (pop)   tail <= r_data;
        end
        FULL2: if (deq) head <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      beat     <= '0;
      rd_count <= '0;
    end else begin
      if (deq) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      if (pop && (rd_count != {CNT_WIDTH{1'b1}})) rd_count <= rd_count + 1'b1;
    end
  end

endmodule
